bus_responder: RTL and testbench
================================

# bus_responder

Memory-side responder for the CPU external bus. Accepts address/data/R_W_n cycles from the CPU, decodes the internal work-RAM window, services reads and writes with a configurable number of wait states, and paces the CPU through `rdy`. It sits between the CPU top-level pins and the system memory map, as the first target on the bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: CPU address width.
- `DATA_WIDTH`, 8: data width.
- `RAM_AW`, 11: RAM index width (2 KiB, mirrored).
- `WINDOW_TOP`, 16'h2000: exclusive upper bound of the RAM window; addresses below it hit, with mirroring every 2^RAM_AW bytes.
- `WAIT_STATES`, 1: wait cycles inserted before a RAM access (0–15).

Ports:
- `clk`, in, 1: system clock; all state on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: cycle request, held high until `ack` is seen (four-phase).
- `A`, in, ADDR_WIDTH: address, stable while `req` is high.
- `R_W_n`, in, 1: 1 = read, 0 = write.
- `d_in`, in, DATA_WIDTH: write data.
- `d_out`, out, DATA_WIDTH: read data, valid while `ack`=1 and `R_W_n`=1.
- `d_oe`, out, 1: drive enable for the shared data bus. High only in DONE on a read.
- `ack`, out, 1: cycle complete.
- `rdy`, out, 1: CPU ready. Low in WAIT and ACCESS.
- `hit`, out, 1: the registered decode result of the current or last cycle.

## Operation
- States are IDLE, WAIT, ACCESS and DONE.
- **IDLE**:
  - Outputs: `rdy`=1, `ack`=0, `d_oe`=0.
  - On `req`=1, latch `A[RAM_AW-1:0]`, `R_W_n` and `d_in`, and set `hit` = (A < WINDOW_TOP).
  - Hit with WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES-1.
  - Hit with WAIT_STATES=0: go to ACCESS.
  - Miss: go to DONE.
- **WAIT**: decrement the counter. At 0, go to ACCESS.
- **ACCESS**: a single RAM cycle.
  - Write: RAM[idx] <= latched data.
  - Read: the `d_out` register <= RAM[idx].
  - Next state is DONE.
- **DONE**:
  - `ack`=1, `rdy`=1, and `d_oe` = latched R_W_n.
  - Stay in DONE until `req`=0, then return to IDLE.
  - A new request is accepted only from IDLE.
- Mirroring: index = A mod 2^RAM_AW, so 0x0000, 0x0800, 0x1000 and 0x1800 alias.
- A write to an unmapped address is discarded.
- Read data to an unmapped address follows Configuration.
- `d_out` holds its value outside DONE. It is not cleared by the return to IDLE.
- A, R_W_n and d_in changing after acceptance have no effect; the latched copies are used.

## Timing
- Reset (async, any state): state=IDLE, `rdy`=1, `ack`=0, `d_oe`=0, `hit`=0, `d_out`=0, counter=0.
- RAM contents are not cleared by reset and survive a reset taken mid-cycle.
- A write aborted by reset before ACCESS does not occur.
- Let edge 0 be the edge that samples `req`=1 in IDLE.
- Mapped cycle: `ack` rises after edge WAIT_STATES+2.
  - WAIT_STATES=1: `rdy` is low for 2 cycles and `ack` rises after edge 3.
- Unmapped cycle: `ack` rises after edge 1, and `rdy` never drops.
- `ack` falls on the first edge that samples `req`=0 in DONE.
  - The earliest next accept is the edge after that.
- If `req` is already high on the cycle IDLE is re-entered, it is accepted immediately as a new cycle.

## Configuration
- `BUS_RESP_OPENBUS_EN` defined:
  - An unmapped read returns the last value transferred on the bus, i.e. the last RAM read data or the last write data seen, including unmapped writes.
  - `d_oe`=1 as for a mapped read.
- Not defined:
  - An unmapped read returns 8'h00.
  - `d_oe` stays 0 for unmapped reads.

## Test plan
- Reset, then write 8'hA5 to 16'h0010, then read 16'h0010. Required: `d_out`=8'hA5, `ack` after edge 3 (WAIT_STATES=1), and `rdy` low for exactly 2 cycles.
- Write 8'h3C to 16'h0805, then read 16'h1805. Required: 8'h3C (mirror).
- Read 16'h4000 after a RAM read of 8'h77. Required: `ack` after edge 1, `hit`=0, and `d_out`=8'h77 with the macro or 8'h00 without it; `rdy` stays 1 throughout.
- Hold `req` high for 5 cycles in DONE. Required: `ack` stays 1, there is no second access, and `ack` falls on the edge after `req` drops.
- Assert `reset_n`=0 while in WAIT of a write of 8'hFF to 16'h0020 (previously 8'h11). Required: outputs at reset values, and a following read returns 8'h11.
- With WAIT_STATES=0, read back the previous write. Required: `ack` after edge 2, and `rdy` low for 1 cycle.

Source files
------------

// File: rtl/bus_responder_if.sv
// CPU external bus bundle between the CPU pins (master) and the memory-side responder (slave).
interface bus_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] A;
    logic                  R_W_n;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  d_oe;
    logic                  ack;
    logic                  rdy;
    logic                  hit;

    modport master (
        output req, A, R_W_n, d_in,
        input  d_out, d_oe, ack, rdy, hit
    );

    modport slave (
        input  req, A, R_W_n, d_in,
        output d_out, d_oe, ack, rdy, hit
    );
endinterface

// File: rtl/bus_responder.sv
// Work-RAM responder on the CPU bus with programmable wait states and four-phase req/ack.
// Optional open-bus read-back of unmapped reads is enabled by defining BUS_RESP_OPENBUS_EN.
module bus_responder #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    RAM_AW      = 11,
    parameter logic [ADDR_WIDTH-1:0] WINDOW_TOP  = 16'h2000,
    parameter int                    WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    bus_responder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state, next_state;
    logic [3:0]            cnt;
    logic                  ack_q;
    logic                  hit_q;
    logic                  rw_lat;
    logic [RAM_AW-1:0]     idx;
    logic [DATA_WIDTH-1:0] data_lat;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] ram [2**RAM_AW];
`ifdef BUS_RESP_OPENBUS_EN
    logic [DATA_WIDTH-1:0] last_bus;
`endif

    logic accept;
    logic addr_hit;

    assign accept   = (state == S_IDLE) && bus.req;
    assign addr_hit = (bus.A < WINDOW_TOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    if (!addr_hit)            next_state = S_DONE;
                    else if (WAIT_STATES > 0) next_state = S_WAIT;
                    else                      next_state = S_ACCESS;
                end
            end
            S_WAIT:   if (cnt == 4'd0) next_state = S_ACCESS;
            S_ACCESS: next_state = S_DONE;
            S_DONE:   if (!bus.req) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // ack is registered from DONE so it lags entry by one edge and drops on the edge seeing req=0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= 4'd0;
            ack_q   <= 1'b0;
            hit_q   <= 1'b0;
            rw_lat  <= 1'b1;
            rd_data <= '0;
`ifdef BUS_RESP_OPENBUS_EN
            last_bus <= '0;
`endif
        end else begin
            ack_q <= (state == S_DONE) && bus.req;
            if (accept) begin
                hit_q  <= addr_hit;
                rw_lat <= bus.R_W_n;
                if (addr_hit)
                    cnt <= WAIT_LOAD;
`ifdef BUS_RESP_OPENBUS_EN
                if (!addr_hit && bus.R_W_n)
                    rd_data <= last_bus;
                if (!bus.R_W_n)
                    last_bus <= bus.d_in;
`else
                if (!addr_hit && bus.R_W_n)
                    rd_data <= '0;
`endif
            end
            if (state == S_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == S_ACCESS && rw_lat) begin
                rd_data <= ram[idx];
`ifdef BUS_RESP_OPENBUS_EN
                last_bus <= ram[idx];
`endif
            end
        end
    end

    // Address and write data carry no reset; RAM survives reset by design
    always_ff @(posedge clk) begin
        if (accept) begin
            idx      <= bus.A[RAM_AW-1:0];
            data_lat <= bus.d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_ACCESS && !rw_lat)
            ram[idx] <= data_lat;
    end

    assign bus.ack   = ack_q;
    assign bus.rdy   = !(state == S_WAIT || state == S_ACCESS);
    assign bus.hit   = hit_q;
    assign bus.d_out = rd_data;
`ifdef BUS_RESP_OPENBUS_EN
    assign bus.d_oe  = ack_q && rw_lat;
`else
    assign bus.d_oe  = ack_q && rw_lat && hit_q;
`endif
endmodule

// File: tb/tb_bus_responder.sv
// Directed table-driven bench for bus_responder: one instance with 1 wait state, one with 0.
module tb_bus_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

`ifdef BUS_RESP_OPENBUS_EN
    localparam bit OPENBUS = 1'b1;
`else
    localparam bit OPENBUS = 1'b0;
`endif

    bus_responder_if bus1();
    bus_responder_if bus0();

    bus_responder #(.WAIT_STATES(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    bus_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

    typedef struct {
        bit          sel0;
        logic [15:0] addr;
        bit          rw;
        logic [7:0]  wdata;
        int          hold;
        int          exp_edge;
        int          exp_rdy_low;
        bit          exp_hit;
        bit          exp_doe;
        bit          chk_dout;
        logic [7:0]  exp_dout;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel0, input bit req, input logic [15:0] a,
                         input bit rw, input logic [7:0] d);
        if (sel0) begin
            bus0.req = req; bus0.A = a; bus0.R_W_n = rw; bus0.d_in = d;
        end else begin
            bus1.req = req; bus1.A = a; bus1.R_W_n = rw; bus1.d_in = d;
        end
    endtask

    task automatic set_req(input bit sel0, input bit req);
        if (sel0) bus0.req = req;
        else      bus1.req = req;
    endtask

    task automatic sample(input bit sel0, output bit ack, output bit rdy, output bit doe,
                          output bit hit, output logic [7:0] dout);
        if (sel0) begin
            ack = bus0.ack; rdy = bus0.rdy; doe = bus0.d_oe; hit = bus0.hit; dout = bus0.d_out;
        end else begin
            ack = bus1.ack; rdy = bus1.rdy; doe = bus1.d_oe; hit = bus1.hit; dout = bus1.d_out;
        end
    endtask

    // Called just after a rising edge; the next edge is edge 0.
    task automatic run_cycle(input vec_t v, input string tag);
        int edge_n;
        int rdy_low;
        bit ack, rdy, doe, hit;
        logic [7:0] dout;
        edge_n = -1;
        rdy_low = 0;
        drive(v.sel0, 1'b1, v.addr, v.rw, v.wdata);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (n == 0) drive(v.sel0, 1'b1, ~v.addr, ~v.rw, ~v.wdata);
            sample(v.sel0, ack, rdy, doe, hit, dout);
            if (!rdy) rdy_low++;
            if (ack) begin
                edge_n = n;
                break;
            end
        end
        check({tag, " ack_edge"}, edge_n, v.exp_edge);
        check({tag, " rdy_low"}, rdy_low, v.exp_rdy_low);
        check({tag, " hit"}, int'(hit), int'(v.exp_hit));
        check({tag, " d_oe"}, int'(doe), int'(v.exp_doe));
        if (v.chk_dout) check({tag, " d_out"}, int'(dout), int'(v.exp_dout));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            sample(v.sel0, ack, rdy, doe, hit, dout);
            check($sformatf("%s hold%0d ack", tag, h), int'(ack), 1);
            check($sformatf("%s hold%0d rdy", tag, h), int'(rdy), 1);
            if (v.chk_dout) check($sformatf("%s hold%0d d_out", tag, h), int'(dout), int'(v.exp_dout));
        end
        set_req(v.sel0, 1'b0);
        @(posedge clk); #1;
        sample(v.sel0, ack, rdy, doe, hit, dout);
        check({tag, " ack_fall"}, int'(ack), 0);
        check({tag, " d_oe_fall"}, int'(doe), 0);
        if (v.chk_dout) check({tag, " d_out_held"}, int'(dout), int'(v.exp_dout));
    endtask

    vec_t vecs[16];
    vec_t rb;

    initial begin
        bit ack, rdy, doe, hit;
        logic [7:0] dout;

        //          sel0 addr     rw wdata  hold edge rl hit doe chk dout
        vecs[0]  = '{0, 16'h0010, 0, 8'hA5, 0, 3, 2, 1, 0, 0, 8'h00};
        vecs[1]  = '{0, 16'h0010, 1, 8'h00, 0, 3, 2, 1, 1, 1, 8'hA5};
        vecs[2]  = '{0, 16'h0805, 0, 8'h3C, 0, 3, 2, 1, 0, 0, 8'h00};
        vecs[3]  = '{0, 16'h1805, 1, 8'h00, 0, 3, 2, 1, 1, 1, 8'h3C};
        vecs[4]  = '{0, 16'h0020, 0, 8'h11, 0, 3, 2, 1, 0, 0, 8'h00};
        vecs[5]  = '{0, 16'h0030, 0, 8'h77, 0, 3, 2, 1, 0, 0, 8'h00};
        vecs[6]  = '{0, 16'h0030, 1, 8'h00, 0, 3, 2, 1, 1, 1, 8'h77};
        vecs[7]  = '{0, 16'h4000, 1, 8'h00, 0, 1, 0, 0, OPENBUS, 1, OPENBUS ? 8'h77 : 8'h00};
        vecs[8]  = '{0, 16'h4000, 0, 8'h5A, 0, 1, 0, 0, 0, 0, 8'h00};
        vecs[9]  = '{0, 16'h7FFF, 1, 8'h00, 0, 1, 0, 0, OPENBUS, 1, OPENBUS ? 8'h5A : 8'h00};
        vecs[10] = '{0, 16'h0010, 1, 8'h00, 5, 3, 2, 1, 1, 1, 8'hA5};
        vecs[11] = '{1, 16'h0040, 0, 8'hC3, 0, 2, 1, 1, 0, 0, 8'h00};
        vecs[12] = '{1, 16'h0040, 1, 8'h00, 0, 2, 1, 1, 1, 1, 8'hC3};
        vecs[13] = '{0, 16'h1FFF, 0, 8'h6E, 0, 3, 2, 1, 0, 0, 8'h00};
        vecs[14] = '{0, 16'h2000, 1, 8'h00, 0, 1, 0, 0, OPENBUS, 1, OPENBUS ? 8'h6E : 8'h00};
        vecs[15] = '{0, 16'h07FF, 1, 8'h00, 0, 3, 2, 1, 1, 1, 8'h6E};

        drive(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00);
        #2;
        for (int s = 0; s < 2; s++) begin
            sample(bit'(s), ack, rdy, doe, hit, dout);
            check($sformatf("reset%0d ack", s), int'(ack), 0);
            check($sformatf("reset%0d rdy", s), int'(rdy), 1);
            check($sformatf("reset%0d d_oe", s), int'(doe), 0);
            check($sformatf("reset%0d hit", s), int'(hit), 0);
            check($sformatf("reset%0d d_out", s), int'(dout), 0);
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            run_cycle(vecs[i], $sformatf("vec%0d", i));

        // Reset taken while a write of FF to 0x0020 sits in WAIT
        drive(1'b0, 1'b1, 16'h0020, 1'b0, 8'hFF);
        @(posedge clk); #1;
        sample(1'b0, ack, rdy, doe, hit, dout);
        check("abort in_wait rdy", int'(rdy), 0);
        reset_n = 1'b0;
        #1;
        sample(1'b0, ack, rdy, doe, hit, dout);
        check("abort ack", int'(ack), 0);
        check("abort rdy", int'(rdy), 1);
        check("abort d_oe", int'(doe), 0);
        check("abort hit", int'(hit), 0);
        check("abort d_out", int'(dout), 0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        rb = '{0, 16'h0020, 1, 8'h00, 0, 3, 2, 1, 1, 1, 8'h11};
        run_cycle(rb, "abort readback");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
